// File: rtl/onchip_mem_arbiter.sv
// Two-master Avalon-MM arbiter for a single-port on-chip RAM.
// Grants one access per clock. In round-robin mode the hold counter limits how many
// consecutive grants one master gets while the other master is waiting.
// Read data arrives one clock after acceptance and is tagged to the master that issued the read.
module onchip_mem_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int MAX_HOLD   = 4,
    parameter int FIXED_PRIO = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     m0_address,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W-1:0]     m0_writedata,
    output logic                  m0_waitrequest,
    output logic [DATA_W-1:0]     m0_readdata,
    output logic                  m0_readdatavalid,
    input  logic [ADDR_W-1:0]     m1_address,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_writedata,
    output logic                  m1_waitrequest,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic                  m1_readdatavalid,
    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic                  mem_clken,
    input  logic [DATA_W-1:0]     mem_readdata
);

    localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

    logic       w_req0;
    logic       w_req1;
    logic       w_grant0;
    logic       w_grant1;
    logic       w_other_req;
    logic       w_rd_accept;
    logic       r_last_grant;   // 0 = m0 owned the last grant, 1 = m1
    logic [3:0] r_hold_cnt;
    logic       r_rd_pend;
    logic       r_rd_owner;

    assign w_req0 = m0_read | m0_write;
    assign w_req1 = m1_read | m1_write;

    // Grant selection: a lone requester wins; under contention use priority or round-robin with hold limit.
    // A hold count of zero means no ownership run is in progress, so the non-last master wins.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (reset) begin
            w_grant0 = 1'b0;
            w_grant1 = 1'b0;
        end else if (FIXED_PRIO != 0) begin
            w_grant0 = w_req0;
            w_grant1 = w_req1 & ~w_req0;
        end else if (w_req0 && w_req1) begin
            if ((r_hold_cnt != 4'd0) && (r_hold_cnt < MAX_HOLD_C)) begin
                w_grant1 = r_last_grant;
            end else begin
                w_grant1 = ~r_last_grant;
            end
            w_grant0 = ~w_grant1;
        end else begin
            w_grant0 = w_req0;
            w_grant1 = w_req1;
        end
    end

    // Master-side handshake and RAM pin drive; an idle bus presents m0's address/data.
    always_comb begin
        m0_waitrequest   = reset | (w_req0 & ~w_grant0);
        m1_waitrequest   = reset | (w_req1 & ~w_grant1);
        m0_readdata      = mem_readdata;
        m1_readdata      = mem_readdata;
        m0_readdatavalid = r_rd_pend & ~r_rd_owner & ~reset;
        m1_readdatavalid = r_rd_pend & r_rd_owner & ~reset;
        mem_chipselect   = w_grant0 | w_grant1;
        mem_write        = (w_grant0 & m0_write) | (w_grant1 & m1_write);
        mem_clken        = ~reset;
        if (w_grant1) begin
            mem_address    = m1_address;
            mem_byteenable = m1_byteenable;
            mem_writedata  = m1_writedata;
        end else begin
            mem_address    = m0_address;
            mem_byteenable = m0_byteenable;
            mem_writedata  = m0_writedata;
        end
    end

    // A read issued together with a write is dropped, so it never produces readdatavalid.
    assign w_rd_accept = (w_grant0 & m0_read & ~m0_write) | (w_grant1 & m1_read & ~m1_write);
    assign w_other_req = w_grant1 ? w_req0 : w_req1;

    // Arbitration history and the one-deep read-return pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= 1'b1;
            r_hold_cnt   <= 4'd0;
            r_rd_pend    <= 1'b0;
            r_rd_owner   <= 1'b0;
        end else begin
            r_rd_pend <= w_rd_accept;
            if (w_grant0 || w_grant1) begin
                r_last_grant <= w_grant1;
                r_rd_owner   <= w_grant1;
                if (FIXED_PRIO != 0) begin
                    r_hold_cnt <= 4'd0;
                end else if ((w_grant1 != r_last_grant) || !w_other_req) begin
                    r_hold_cnt <= 4'd1;
                end else if (r_hold_cnt < MAX_HOLD_C) begin
                    r_hold_cnt <= r_hold_cnt + 4'd1;
                end else begin
                    r_hold_cnt <= r_hold_cnt;
                end
            end else begin
                r_last_grant <= r_last_grant;
                r_rd_owner   <= r_rd_owner;
                r_hold_cnt   <= r_hold_cnt;
            end
        end
    end

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Bench for onchip_mem_arbiter: instance 0 is round-robin and instance 1 is fixed-priority.
// Each instance has its own RAM model. A behavioural model predicts every output on every cycle.
module tb_onchip_mem_arbiter;
    localparam int MAXH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    // Master-side inputs and outputs, indexed [instance][master].
    logic [1:0][1:0]       rd, wr, wt, rv;
    logic [1:0][1:0][9:0]  ad;
    logic [1:0][1:0][3:0]  be;
    logic [1:0][1:0][31:0] wd, rdat;
    // RAM-side outputs, indexed [instance].
    logic [1:0][9:0]       m_ad;
    logic [1:0][3:0]       m_be;
    logic [1:0]            m_cs, m_wr, m_ck;
    logic [1:0][31:0]      m_wd;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [31:0] ram [0:1023];
        logic [31:0] rdq;
        onchip_mem_arbiter #(.ADDR_W(10), .DATA_W(32), .MAX_HOLD(MAXH), .FIXED_PRIO(g)) u_dut (
            .clk(clk), .reset(reset),
            .m0_address(ad[g][0]), .m0_byteenable(be[g][0]), .m0_read(rd[g][0]), .m0_write(wr[g][0]),
            .m0_writedata(wd[g][0]), .m0_waitrequest(wt[g][0]), .m0_readdata(rdat[g][0]),
            .m0_readdatavalid(rv[g][0]),
            .m1_address(ad[g][1]), .m1_byteenable(be[g][1]), .m1_read(rd[g][1]), .m1_write(wr[g][1]),
            .m1_writedata(wd[g][1]), .m1_waitrequest(wt[g][1]), .m1_readdata(rdat[g][1]),
            .m1_readdatavalid(rv[g][1]),
            .mem_address(m_ad[g]), .mem_byteenable(m_be[g]), .mem_chipselect(m_cs[g]),
            .mem_write(m_wr[g]), .mem_writedata(m_wd[g]), .mem_clken(m_ck[g]), .mem_readdata(rdq)
        );
        // Single-port byte-enabled RAM with one-cycle read latency.
        always @(posedge clk) begin
            if (m_ck[g] && m_cs[g]) begin
                if (m_wr[g]) begin
                    for (int b = 0; b < 4; b++)
                        if (m_be[g][b]) ram[m_ad[g]][8*b +: 8] <= m_wd[g][8*b +: 8];
                end else begin
                    rdq <= ram[m_ad[g]];
                end
            end
        end
    end

    // Behavioural model state.
    int          owner [2];
    int          streak [2];
    int          glast [2];
    bit          pend [2];
    int          pend_own [2];
    logic [31:0] pend_data [2];
    bit          pend_known [2];
    logic [31:0] shadow [2][1024];
    bit          known [2][1024];
    logic [1:0][1:0]       cap_wt, cap_rv;
    logic [1:0][1:0][31:0] cap_rd;
    int tests = 0;
    int fails = 0;

    task automatic chk1(input string nm, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Predict and compare one cycle for instance d, then advance the model.
    task automatic model_cycle(input int d);
        bit r0, r1, oth;
        int g, src;
        logic [31:0] w;
        r0 = rd[d][0] | wr[d][0];
        r1 = rd[d][1] | wr[d][1];
        cap_wt[d] = wt[d];
        cap_rv[d] = rv[d];
        cap_rd[d] = rdat[d];
        if (reset) begin
            chk1($sformatf("d%0d_rst_wait0", d), wt[d][0], 1'b1);
            chk1($sformatf("d%0d_rst_wait1", d), wt[d][1], 1'b1);
            chk1($sformatf("d%0d_rst_cs", d), m_cs[d], 1'b0);
            chk1($sformatf("d%0d_rst_wr", d), m_wr[d], 1'b0);
            chk1($sformatf("d%0d_rst_rv0", d), rv[d][0], 1'b0);
            chk1($sformatf("d%0d_rst_rv1", d), rv[d][1], 1'b0);
            chk1($sformatf("d%0d_rst_clken", d), m_ck[d], 1'b0);
            owner[d] = 1; streak[d] = 0; pend[d] = 1'b0; glast[d] = -1;
            return;
        end
        if (r0 && r1) begin
            if (d == 1) g = 0;
            else if (streak[d] > 0 && streak[d] < MAXH) g = owner[d];
            else g = 1 - owner[d];
        end else if (r0) g = 0;
        else if (r1) g = 1;
        else g = -1;
        src = (g >= 0) ? g : 0;
        chk1($sformatf("d%0d_wait0", d), wt[d][0], r0 && g != 0);
        chk1($sformatf("d%0d_wait1", d), wt[d][1], r1 && g != 1);
        chk1($sformatf("d%0d_cs", d), m_cs[d], g >= 0);
        chk1($sformatf("d%0d_memwr", d), m_wr[d], (g >= 0) && wr[d][src]);
        chk1($sformatf("d%0d_clken", d), m_ck[d], 1'b1);
        chk32($sformatf("d%0d_addr", d), 32'(m_ad[d]), 32'(ad[d][src]));
        chk32($sformatf("d%0d_be", d), 32'(m_be[d]), 32'(be[d][src]));
        chk32($sformatf("d%0d_wdata", d), m_wd[d], wd[d][src]);
        chk1($sformatf("d%0d_rv0", d), rv[d][0], pend[d] && pend_own[d] == 0);
        chk1($sformatf("d%0d_rv1", d), rv[d][1], pend[d] && pend_own[d] == 1);
        if (pend[d] && pend_known[d]) begin
            chk32($sformatf("d%0d_rdata0", d), rdat[d][0], pend_data[d]);
            chk32($sformatf("d%0d_rdata1", d), rdat[d][1], pend_data[d]);
        end
        pend[d] = (g >= 0) && rd[d][src] && !wr[d][src];
        if (pend[d]) begin
            pend_own[d]   = g;
            pend_data[d]  = shadow[d][ad[d][src]];
            pend_known[d] = known[d][ad[d][src]];
        end
        if (g >= 0 && wr[d][src]) begin
            w = shadow[d][ad[d][src]];
            for (int b = 0; b < 4; b++)
                if (be[d][src][b]) w[8*b +: 8] = wd[d][src][8*b +: 8];
            shadow[d][ad[d][src]] = w;
            if (be[d][src] == 4'hF) known[d][ad[d][src]] = 1'b1;
        end
        if (g >= 0) begin
            oth = (g == 0) ? r1 : r0;
            if (g != owner[d] || !oth) streak[d] = 1;
            else if (streak[d] < MAXH) streak[d] = streak[d] + 1;
            owner[d] = g;
        end
        glast[d] = g;
    endtask

    task automatic step();
        @(negedge clk);
        model_cycle(0);
        model_cycle(1);
        @(posedge clk);
        #1;
    endtask

    task automatic setm(input int d, input int m, input logic r, input logic w, input logic [9:0] a,
                        input logic [3:0] b, input logic [31:0] data);
        rd[d][m] = r; wr[d][m] = w; ad[d][m] = a; be[d][m] = b; wd[d][m] = data;
    endtask

    task automatic idle_all();
        for (int d = 0; d < 2; d++)
            for (int m = 0; m < 2; m++) setm(d, m, 1'b0, 1'b0, 10'd0, 4'h0, 32'h0);
    endtask

    initial begin
        for (int d = 0; d < 2; d++)
            for (int a = 0; a < 1024; a++) known[d][a] = 1'b0;
        idle_all();
        reset = 1'b1;
        #1;
        repeat (3) step();
        reset = 1'b0;

        // Write then read back on m0.
        setm(0, 0, 1'b0, 1'b1, 10'd5, 4'hF, 32'hDEADBEEF);
        step();
        chk1("t1_wr_wait", cap_wt[0][0], 1'b0);
        setm(0, 0, 1'b1, 1'b0, 10'd5, 4'hF, 32'h0);
        step();
        chk1("t1_rd_wait", cap_wt[0][0], 1'b0);
        idle_all();
        step();
        chk1("t1_rv", cap_rv[0][0], 1'b1);
        chk32("t1_data", cap_rd[0][0], 32'hDEADBEEF);

        // Partial write at the top word.
        setm(0, 1, 1'b0, 1'b1, 10'd1023, 4'hF, 32'hFFFFFFFF);
        step();
        setm(0, 1, 1'b0, 1'b1, 10'd1023, 4'h3, 32'h12345678);
        step();
        idle_all();
        setm(0, 0, 1'b1, 1'b0, 10'd1023, 4'hF, 32'h0);
        step();
        idle_all();
        step();
        chk1("t3_rv", cap_rv[0][0], 1'b1);
        chk32("t3_data", cap_rd[0][0], 32'hFFFF5678);

        // Simultaneous read and write: the write wins and no read data returns.
        setm(0, 0, 1'b1, 1'b1, 10'd7, 4'hF, 32'hCAFEF00D);
        step();
        chk1("t4_wait", cap_wt[0][0], 1'b0);
        idle_all();
        step();
        chk1("t4_no_rv", cap_rv[0][0], 1'b0);
        setm(0, 0, 1'b1, 1'b0, 10'd7, 4'hF, 32'h0);
        step();
        idle_all();
        step();
        chk32("t4_data", cap_rd[0][0], 32'hCAFEF00D);

        // Continuous contention from reset: four grants each, alternating, starting with m0.
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        setm(0, 0, 1'b1, 1'b0, 10'd5, 4'hF, 32'h0);
        setm(0, 1, 1'b1, 1'b0, 10'd1023, 4'hF, 32'h0);
        for (int i = 0; i < 12; i++) begin
            step();
            chk32($sformatf("t2_model_grant%0d", i), 32'(glast[0]), ((i / 4) % 2 == 0) ? 32'd0 : 32'd1);
            chk1($sformatf("t2_wait0_%0d", i), cap_wt[0][0], (i / 4) % 2 != 0);
        end
        idle_all();
        step();

        // Reset right after an accepted m1 read suppresses its data.
        setm(0, 1, 1'b1, 1'b0, 10'd5, 4'hF, 32'h0);
        step();
        chk1("t5_accept", cap_wt[0][1], 1'b0);
        idle_all();
        reset = 1'b1;
        step();
        chk1("t5_rv1", cap_rv[0][1], 1'b0);
        chk1("t5_wait0", cap_wt[0][0], 1'b1);
        chk1("t5_wait1", cap_wt[0][1], 1'b1);
        step();
        reset = 1'b0;
        setm(0, 0, 1'b1, 1'b0, 10'd5, 4'hF, 32'h0);
        setm(0, 1, 1'b1, 1'b0, 10'd5, 4'hF, 32'h0);
        step();
        chk1("t5_first_m0", cap_wt[0][0], 1'b0);
        chk1("t5_first_m1", cap_wt[0][1], 1'b1);
        idle_all();
        step();

        // Fixed priority: m0 wins every contended cycle; m1 gets the bus once m0 drops.
        setm(1, 0, 1'b1, 1'b0, 10'd3, 4'hF, 32'h0);
        setm(1, 1, 1'b1, 1'b0, 10'd4, 4'hF, 32'h0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk1($sformatf("t6_wait1_%0d", i), cap_wt[1][1], 1'b1);
            chk1($sformatf("t6_wait0_%0d", i), cap_wt[1][0], 1'b0);
        end
        setm(1, 0, 1'b0, 1'b0, 10'd3, 4'hF, 32'h0);
        step();
        chk1("t6_m1_granted", cap_wt[1][1], 1'b0);
        idle_all();
        step();

        // Random traffic on both instances; a master holds its request until accepted.
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            for (int d = 0; d < 2; d++) begin
                for (int m = 0; m < 2; m++) begin
                    if (!(rd[d][m] || wr[d][m]) || !cap_wt[d][m]) begin
                        if ($urandom_range(0, 9) < 6) begin
                            int k;
                            k = $urandom_range(0, 7);
                            setm(d, m, k < 4 || k == 7, k >= 4,
                                 ($urandom_range(0, 7) == 0) ? 10'd1023 : 10'($urandom_range(0, 15)),
                                 ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15)),
                                 $urandom);
                        end else begin
                            setm(d, m, 1'b0, 1'b0, 10'($urandom_range(0, 1023)), 4'($urandom_range(0, 15)), $urandom);
                        end
                    end
                end
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
